// File: rtl/sar_scan_sequencer.sv
// Round-robin scan sequencer for a SAR ADC: selects an enabled channel, settles the mux,
// runs one conversion with an eoc-edge handshake and timeout, then reports the result.
module sar_scan_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 32,
    localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [9:0]        sar,
    input  logic              eoc,
    output logic              cnvst,
    output logic [CW-1:0]     ch_sel,
    output logic [9:0]        result_data,
    output logic [CW-1:0]     result_ch,
    output logic              result_valid,
    output logic              timeout_err,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, SELECT, SETTLE, START, WAIT_EOC, STORE} state_t;

    state_t        state, state_n;
    logic [3:0]    settle_cnt;
    logic [7:0]    tmo_cnt;
    logic [CW-1:0] last_ch;
    logic [CW-1:0] next_ch;
    logic [CW-1:0] idx;
    logic          found;
    logic          eoc_d;
    logic          eoc_edge;
    logic          tmo_hit;

    assign eoc_edge = eoc & ~eoc_d;
    // Counter is cleared in START, so the START cycle itself is the first timeout cycle.
    assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT_CYC - 2));

    // First enabled channel after last_ch; k == NUM_CH lands back on last_ch itself.
    always_comb begin
        next_ch = last_ch;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = CW'((int'(last_ch) + k) % NUM_CH);
            if (!found && ch_mask[idx]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (scan_en && |ch_mask) state_n = SELECT;
            SELECT:   state_n = (|ch_mask) ? SETTLE : IDLE;
            SETTLE:   if (settle_cnt == 4'd0) state_n = START;
            START:    state_n = WAIT_EOC;
            WAIT_EOC: begin
                if (eoc_edge)     state_n = STORE;
                else if (tmo_hit) state_n = scan_en ? SELECT : IDLE;
            end
            STORE:    state_n = scan_en ? SELECT : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    assign cnvst        = (state == START) || (state == WAIT_EOC);
    assign result_valid = (state == STORE);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            ch_sel      <= '0;
            result_data <= '0;
            result_ch   <= '0;
            timeout_err <= 1'b0;
            eoc_d       <= 1'b0;
            last_ch     <= CW'(NUM_CH - 1);
        end else begin
            state       <= state_n;
            eoc_d       <= eoc;
            timeout_err <= 1'b0;
            case (state)
                SELECT: begin
                    if (|ch_mask) ch_sel <= next_ch;
                    settle_cnt <= 4'(SETTLE_CYC - 1);
                end
                SETTLE: if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                START:  tmo_cnt <= '0;
                WAIT_EOC: begin
                    if (eoc_edge) begin
                        result_data <= sar;
                        result_ch   <= ch_sel;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        last_ch     <= ch_sel;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                STORE:  last_ch <= result_ch;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sar_scan_sequencer.md
SAR_SCAN_SEQUENCER -- requirements
Module: sar_scan_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of analog input channels; ch_mask width is NUM_CH and ch_sel/result_ch width is log2(NUM_CH).
REQ-002 Parameter SETTLE_CYC, default 4: clk cycles of input-mux settling before each conversion; legal range 1..15.
REQ-003 Parameter TIMEOUT_CYC, default 32: maximum clk cycles to wait for eoc after cnvst rises; legal range 2..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 scan_en  input  1  level; 1 = keep scanning enabled channels continuously.
REQ-007 ch_mask  input  NUM_CH  bit i = 1 enables channel i.
REQ-008 sar  input  10  conversion result from the SAR logic.
REQ-009 eoc  input  1  end-of-conversion from the SAR logic.
REQ-010 cnvst  output  1  conversion start to the SAR logic, held high for the whole conversion.
REQ-011 ch_sel  output  log2(NUM_CH)  analog mux select.
REQ-012 result_data  output  10  captured conversion code.
REQ-013 result_ch  output  log2(NUM_CH)  channel of result_data.
REQ-014 result_valid  output  1  one-cycle pulse; result_data/result_ch are valid.
REQ-015 timeout_err  output  1  one-cycle pulse; the current conversion timed out.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL use the states IDLE, SELECT, SETTLE, START, WAIT_EOC and STORE, all registered.
REQ-018 IDLE: when scan_en=1 and ch_mask!=0, go to SELECT; otherwise remain in IDLE.
REQ-019 SELECT (1 cycle): choose the first enabled channel strictly after last_ch in round-robin order, wrapping from NUM_CH-1 to 0; last_ch itself is chosen only if it is the sole enabled channel; register ch_sel; go to SETTLE. If ch_mask=0, go to IDLE instead.
REQ-020 SETTLE: hold ch_sel for exactly SETTLE_CYC cycles using a down-counter, then go to START.
REQ-021 START (1 cycle): cnvst=1; clear the timeout counter; go to WAIT_EOC.
REQ-022 WAIT_EOC: cnvst stays 1; eoc is registered (eoc_d) and a rising edge (eoc & ~eoc_d) marks completion; a level-high eoc present at START entry is not accepted.
REQ-023 WAIT_EOC: on an eoc rising edge, capture sar into result_data and ch_sel into result_ch in the same edge, drop cnvst, and go to STORE.
REQ-024 WAIT_EOC: if TIMEOUT_CYC cycles elapse with no rising edge, pulse timeout_err for 1 cycle, drop cnvst, leave result_data unchanged, update last_ch, and go to SELECT.
REQ-025 If an eoc rising edge and the timeout coincide in the same cycle, the eoc edge wins and no timeout_err is raised.
REQ-026 STORE (1 cycle): result_valid=1; last_ch <= result_ch; next state is SELECT if scan_en=1, else IDLE.
REQ-027 Latency, cnvst rise to result_valid: eoc-edge cycle + 1; SELECT to cnvst rise: SETTLE_CYC + 1 cycles.
REQ-028 ch_mask SHALL be sampled only in SELECT; mask changes mid-conversion do not abort the conversion in progress.
REQ-029 scan_en falling mid-conversion SHALL let the current conversion finish (STORE or timeout), then go to IDLE; a timeout with scan_en=0 goes to IDLE, not SELECT.
REQ-030 ch_sel SHALL change only in SELECT, so it is stable from SETTLE through WAIT_EOC.
REQ-031 result_valid and timeout_err SHALL never be high in the same cycle.

Reset
REQ-032 While rst=1 at a clock edge: state=IDLE; cnvst=0; ch_sel=0; result_data=0; result_ch=0; result_valid=0; timeout_err=0; busy=0; eoc_d=0; last_ch=NUM_CH-1, so the first scan starts at channel 0.
REQ-033 Reset asserted in any state, including WAIT_EOC with cnvst=1, SHALL force the REQ-032 values at the next edge; no partial result is emitted.

Verification
REQ-034 rst 3 cycles, then scan_en=1, ch_mask=4'b1111, eoc rises 12 cycles after cnvst with sar=10'h2A5 -> cnvst high 12 cycles, result_valid once with result_data=10'h2A5 and result_ch=0, then ch_sel=1.
REQ-035 ch_mask=4'b1010, continuous scan -> result_ch sequence 1,3,1,3; channels 0 and 2 are never selected.
REQ-036 eoc held low -> timeout_err pulses exactly TIMEOUT_CYC cycles after START; cnvst drops; result_valid stays 0; the next enabled channel is selected.
REQ-037 eoc already high at START -> it is ignored until eoc falls and rises again; result is captured on that second edge.
REQ-038 rst=1 during WAIT_EOC -> next cycle cnvst=0, busy=0, ch_sel=0, no result_valid; the restart begins at channel 0.
REQ-039 scan_en dropped during SETTLE of channel 2 -> channel 2 converts and stores, then IDLE with busy=0 and no further cnvst.
